// File: rtl/nios_ii_base_onchip_memory_arbiter.sv
// Two-master arbiter in front of a single-port 64-bit on-chip RAM with fixed read latency of 1.
// Out-of-range accesses are accepted but never reach the RAM; reads of them return zero.
module nios_ii_base_onchip_memory_arbiter #(
  parameter int unsigned NUMWORDS = 16000,
  parameter int unsigned ADDR_W   = 14
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic [7:0]        m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [63:0]       m0_writedata,
  output logic              m0_waitrequest,
  output logic [63:0]       m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic [7:0]        m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [63:0]       m1_writedata,
  output logic              m1_waitrequest,
  output logic [63:0]       m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] mem_address,
  output logic [7:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [63:0]       mem_writedata,
  output logic              mem_clken,
  input  logic [63:0]       mem_readdata,

  input  logic              freeze,
  output logic [15:0]       oob_count
);

  logic              r_ready;
  logic              r_last_grant;
  logic              r_rv_valid;
  logic              r_rv_id;
  logic              r_rv_oob;
  logic [15:0]       r_oob_count;

  logic              w_req0;
  logic              w_req1;
  logic              w_en;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_any;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_addr_ext;
  logic              w_wr;
  logic              w_oob;
  logic              w_rv0;
  logic              w_rv1;

  assign w_req0 = m0_read | m0_write;
  assign w_req1 = m1_read | m1_write;

  // r_ready keeps the edge that releases reset from also granting a request.
  assign w_en   = r_ready & ~freeze;
  assign w_gnt0 = w_en & w_req0 & (~w_req1 | r_last_grant);
  assign w_gnt1 = w_en & w_req1 & (~w_req0 | ~r_last_grant);
  assign w_any  = w_gnt0 | w_gnt1;

  assign m0_waitrequest = w_req0 & ~w_gnt0;
  assign m1_waitrequest = w_req1 & ~w_gnt1;

  // With no grant the mux falls back to m0, which is what the RAM sees.
  assign w_addr     = w_gnt1 ? m1_address : m0_address;
  assign w_wr       = w_gnt1 ? m1_write   : m0_write;
  assign w_addr_ext = 32'(w_addr);
  assign w_oob      = w_any & (w_addr_ext >= NUMWORDS);

  assign mem_address    = w_addr;
  assign mem_byteenable = w_gnt1 ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = w_gnt1 ? m1_writedata  : m0_writedata;
  assign mem_chipselect = w_any & ~w_oob;
  assign mem_write      = w_any & ~w_oob & w_wr;
  assign mem_clken      = 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ready      <= 1'b0;
      r_last_grant <= 1'b1;
      r_rv_valid   <= 1'b0;
      r_rv_id      <= 1'b0;
      r_rv_oob     <= 1'b0;
      r_oob_count  <= 16'd0;
    end else begin
      r_ready <= 1'b1;
      if (w_any) begin
        r_last_grant <= w_gnt1;
      end
      r_rv_valid <= w_any & ~w_wr;
      r_rv_id    <= w_gnt1;
      r_rv_oob   <= w_oob;
      if (w_oob && (r_oob_count != 16'hFFFF)) begin
        r_oob_count <= r_oob_count + 16'd1;
      end
    end
  end

  // Read return: the RAM q is valid now for the address presented at the last edge.
  assign w_rv0 = r_rv_valid & ~r_rv_id;
  assign w_rv1 = r_rv_valid &  r_rv_id;

  assign m0_readdatavalid = w_rv0;
  assign m1_readdatavalid = w_rv1;
  assign m0_readdata      = (w_rv0 && !r_rv_oob) ? mem_readdata : 64'h0;
  assign m1_readdata      = (w_rv1 && !r_rv_oob) ? mem_readdata : 64'h0;

  assign oob_count = r_oob_count;

endmodule

// File: tb/tb_nios_ii_base_onchip_memory_arbiter.sv
// Randomized bench for the on-chip memory arbiter, checked against a transaction-level model
// that tracks fairness, read returns, a shadow copy of RAM contents and the out-of-range count.
module tb_nios_ii_base_onchip_memory_arbiter;
  localparam int NUMWORDS = 16000;
  localparam int ADDR_W   = 14;
  localparam int DEPTH    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] m0_address, m1_address;
  logic [7:0]        m0_byteenable, m1_byteenable;
  logic              m0_read, m0_write, m1_read, m1_write;
  logic [63:0]       m0_writedata, m1_writedata;
  logic              m0_waitrequest, m1_waitrequest;
  logic [63:0]       m0_readdata, m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic [ADDR_W-1:0] mem_address;
  logic [7:0]        mem_byteenable;
  logic              mem_chipselect, mem_write, mem_clken;
  logic [63:0]       mem_writedata, mem_readdata;
  logic              freeze;
  logic [15:0]       oob_count;

  always #5 clk = ~clk;

  nios_ii_base_onchip_memory_arbiter #(.NUMWORDS(NUMWORDS), .ADDR_W(ADDR_W)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_clken(mem_clken), .mem_readdata(mem_readdata),
    .freeze(freeze), .oob_count(oob_count)
  );

  // Behavioural RAM: byte-lane writes, registered q one cycle after the address edge.
  logic [63:0] ram [DEPTH];
  logic [63:0] ram_q;
  always @(posedge clk) begin
    if (mem_chipselect) begin
      ram_q <= ram[mem_address];
      if (mem_write) begin
        for (int b = 0; b < 8; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] = mem_writedata[8*b +: 8];
      end
    end
  end
  assign mem_readdata = ram_q;

  // Reference model state
  logic [63:0] shadow [DEPTH];
  int          m_last;
  int          m_ready;
  int          m_rv_valid;
  int          m_rv_id;
  logic [63:0] m_rv_data;
  int          m_oob;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic start_reset();
    reset_n    = 1'b0;
    m_last     = 1;
    m_ready    = 0;
    m_rv_valid = 0;
    m_oob      = 0;
  endtask

  task automatic set_m(input int m, input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                       input logic [7:0] be, input logic [63:0] wd);
    if (m == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = wd;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = wd;
    end
  endtask

  // One clock: check outputs at the falling edge from the model, then advance the model.
  task automatic run_cycle(input bit release_rst);
    logic              req0, req1, wr, inr, exp_cs;
    logic [ADDR_W-1:0] a;
    logic [7:0]        be;
    logic [63:0]       wd;
    int                win;
    @(negedge clk);
    req0 = m0_read | m0_write;
    req1 = m1_read | m1_write;
    win  = -1;
    if (m_ready != 0 && !freeze && reset_n) begin
      if (req0 && req1) win = (m_last == 0) ? 1 : 0;
      else if (req0)    win = 0;
      else if (req1)    win = 1;
    end
    if (win == 1) begin wr = m1_write; a = m1_address; be = m1_byteenable; wd = m1_writedata; end
    else          begin wr = m0_write; a = m0_address; be = m0_byteenable; wd = m0_writedata; end
    inr    = (int'(a) < NUMWORDS);
    exp_cs = (win >= 0) && inr;
    chk_val("m0_wait", 64'(m0_waitrequest), 64'(req0 && win != 0));
    chk_val("m1_wait", 64'(m1_waitrequest), 64'(req1 && win != 1));
    chk_val("mem_cs",  64'(mem_chipselect), 64'(exp_cs));
    chk_val("mem_wr",  64'(mem_write),      64'(exp_cs && wr));
    chk_val("mem_clken", 64'(mem_clken), 64'd1);
    if (exp_cs) begin
      chk_val("mem_addr", 64'(mem_address), 64'(a));
      chk_val("mem_be",   64'(mem_byteenable), 64'(be));
      if (wr) chk_val("mem_wd", mem_writedata, wd);
    end
    chk_val("m0_rdv", 64'(m0_readdatavalid), 64'(m_rv_valid != 0 && m_rv_id == 0));
    chk_val("m1_rdv", 64'(m1_readdatavalid), 64'(m_rv_valid != 0 && m_rv_id == 1));
    chk_val("m0_rdata", m0_readdata, (m_rv_valid != 0 && m_rv_id == 0) ? m_rv_data : 64'h0);
    chk_val("m1_rdata", m1_readdata, (m_rv_valid != 0 && m_rv_id == 1) ? m_rv_data : 64'h0);
    chk_val("oob_count", 64'(oob_count), 64'(m_oob));
    if (release_rst) reset_n = 1'b1;
    @(posedge clk);
    if (reset_n) begin
      m_rv_valid = (win >= 0 && !wr) ? 1 : 0;
      m_rv_id    = win;
      m_rv_data  = inr ? shadow[a] : 64'h0;
      if (win >= 0 && wr && inr)
        for (int b = 0; b < 8; b++) if (be[b]) shadow[a][8*b +: 8] = wd[8*b +: 8];
      if (win >= 0 && !inr && m_oob < 65535) m_oob++;
      if (win >= 0) m_last = win;
      m_ready = 1;
    end
    #1;
  endtask

  task automatic idle();
    set_m(0, 0, 0, '0, 8'hFF, 64'h0);
    set_m(1, 0, 0, '0, 8'hFF, 64'h0);
    freeze = 1'b0;
  endtask

  task automatic full_reset();
    idle();
    start_reset();
    run_cycle(0);
    run_cycle(1);
    run_cycle(0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]    = {$urandom, $urandom};
      shadow[i] = ram[i];
    end
    full_reset();

    // Alternating contention on reads of 5 and 6
    set_m(0, 1, 0, 14'd5, 8'hFF, 64'h0);
    set_m(1, 1, 0, 14'd6, 8'hFF, 64'h0);
    repeat (4) run_cycle(0);
    idle();
    run_cycle(0);

    // Partial write by m1 then read-back by m0
    set_m(1, 0, 1, 14'd100, 8'h0F, 64'hDEADBEEF_01234567);
    run_cycle(0);
    idle();
    set_m(0, 1, 0, 14'd100, 8'hFF, 64'h0);
    run_cycle(0);
    idle();
    run_cycle(0);

    // Out-of-range read and write
    full_reset();
    set_m(0, 1, 0, 14'd16000, 8'hFF, 64'h0);
    run_cycle(0);
    idle();
    set_m(1, 0, 1, 14'd16383, 8'hFF, 64'h1234);
    run_cycle(0);
    idle();
    run_cycle(0);
    chk_val("s_oob_two", 64'(oob_count), 64'd2);

    // Freeze holds off a read for three cycles
    set_m(0, 1, 0, 14'd9, 8'hFF, 64'h0);
    freeze = 1'b1;
    repeat (3) run_cycle(0);
    freeze = 1'b0;
    run_cycle(0);
    idle();
    run_cycle(0);

    // Reset during an in-flight read; then contention goes to m0
    set_m(1, 1, 0, 14'd7, 8'hFF, 64'h0);
    run_cycle(0);
    start_reset();
    set_m(0, 1, 0, 14'd11, 8'hFF, 64'h0);
    set_m(1, 1, 0, 14'd12, 8'hFF, 64'h0);
    run_cycle(1);
    run_cycle(0);
    run_cycle(0);
    idle();
    run_cycle(0);

    // Random traffic with occasional freeze and reset
    for (int n = 0; n < 800; n++) begin
      for (int m = 0; m < 2; m++)
        set_m(m, 1'($urandom % 2), 1'($urandom % 4 == 0),
              ($urandom % 8 == 0) ? 14'(16000 + $urandom % 384) : 14'($urandom % 32),
              8'($urandom), {$urandom, $urandom});
      freeze = 1'($urandom % 10 == 0);
      if ($urandom % 100 == 0) begin
        start_reset();
        run_cycle(1);
      end else begin
        run_cycle(0);
      end
    end

    // Saturation of the out-of-range counter
    full_reset();
    set_m(0, 1, 0, 14'd16383, 8'hFF, 64'h0);
    repeat (65540) run_cycle(0);
    idle();
    run_cycle(0);
    chk_val("s_oob_sat", 64'(oob_count), 64'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/nios_ii_base_onchip_memory_arbiter.md
NIOS_II_BASE_ONCHIP_MEMORY_ARBITER -- requirements
Module: nios_ii_base_onchip_memory_arbiter

Interface
REQ-001 The block SHALL have parameter NUMWORDS, default 16000, number of valid 64-bit words in the shared RAM.
REQ-002 The block SHALL have parameter ADDR_W, default 14, word-address width.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset, with ports as follows:
  clk  in  1  single clock, rising edge.
  reset_n  in  1  asynchronous active-low reset.
REQ-004 Master port m0 SHALL have:
  m0_address  in  ADDR_W  word address.
  m0_byteenable  in  8  byte lanes.
  m0_read  in  1  read request.
  m0_write  in  1  write request.
  m0_writedata  in  64  write data.
  m0_waitrequest  out  1  request not accepted this cycle.
  m0_readdata  out  64  read data.
  m0_readdatavalid  out  1  m0_readdata valid.
REQ-005 Master port m1 SHALL have the same signals as m0, with prefix m1_.
REQ-006 The RAM side SHALL have:
  mem_address  out  ADDR_W  address to RAM.
  mem_byteenable  out  8  byte lanes to RAM.
  mem_chipselect  out  1  RAM access this cycle.
  mem_write  out  1  RAM write.
  mem_writedata  out  64  RAM write data.
  mem_clken  out  1  RAM clock enable.
  mem_readdata  in  64  RAM q, valid in the cycle after the address edge.
REQ-007 Control ports SHALL be:
  freeze  in  1  block new grants.
  oob_count  out  16  saturating count of out-of-range accesses.

Function
REQ-008 A master SHALL be requesting when its read or its write is high; if both are high, the request SHALL be a write and the read SHALL be ignored.
REQ-009 Grant SHALL be combinational from the requests and the registered last_grant bit: a sole requester is granted, and under contention the master not equal to last_grant is granted.
REQ-010 The granted master's waitrequest SHALL be 0 and every other requesting master's waitrequest SHALL be 1; a non-requesting master's waitrequest SHALL be 0.
REQ-011 last_grant SHALL update to the granted master on every clock edge on which a grant occurs, and SHALL hold otherwise.
REQ-012 With freeze high, there SHALL be no grants: both waitrequests are 1 for requesting masters, mem_chipselect is 0, last_grant holds, and in-flight readdatavalid still completes.
REQ-013 For an in-range grant (address < NUMWORDS), mem_address, mem_byteenable and mem_writedata SHALL equal the granted master's signals, mem_chipselect SHALL be 1, and mem_write SHALL equal the granted write, all combinationally in the same cycle.
REQ-014 With no grant, mem_chipselect and mem_write SHALL be 0; mem_address, mem_byteenable and mem_writedata SHALL be don't-care and driven from m0.
REQ-015 mem_clken SHALL be 1 at all times.
REQ-016 An in-range read accepted at edge N SHALL produce readdatavalid = 1 for exactly one cycle on the granting master after edge N, with readdata = mem_readdata; the read latency is fixed at 1.
REQ-017 The read-return tag (valid bit, master id, oob bit) SHALL be registered; the other master's readdatavalid SHALL be 0 in that cycle.
REQ-018 Back-to-back reads, including alternating masters, SHALL be accepted every cycle with no bubble.
REQ-019 An out-of-range access (address >= NUMWORDS) SHALL be accepted with normal waitrequest and fairness, but SHALL drive mem_chipselect = 0.
REQ-020 An out-of-range write SHALL be dropped.
REQ-021 An out-of-range read SHALL return readdata = 64'h0 with readdatavalid asserted at latency 1.
REQ-022 oob_count SHALL increment by 1 per accepted out-of-range access and SHALL saturate at 16'hFFFF.
REQ-023 readdata SHALL be 64'h0 whenever readdatavalid is 0.

Reset
REQ-024 reset_n low SHALL asynchronously clear: last_grant = 1 (m0 wins first contention), the read-return tag, both readdatavalids = 0, and oob_count = 0.
REQ-025 A read in flight when reset asserts SHALL be discarded, with no readdatavalid after reset release.
REQ-026 Deassertion of reset_n SHALL be synchronous to clk, with no grant in the release cycle's preceding edge.

Verification
REQ-027 Scenario: after reset, m0 and m1 both read, address 5 and 6 held, for 4 cycles -> grants m0,m1,m0,m1; readdatavalid alternates one cycle later with mem_readdata routed to the correct master.
REQ-028 Scenario: m1 writes 64'hDEADBEEF_01234567 at address 100 with byteenable 8'h0F, then m0 reads address 100 -> mem_write=1 and mem_byteenable=8'h0F in the write cycle; m0_readdatavalid is 1 on the cycle after the read grant.
REQ-029 Scenario: m0 reads address 16000 and m1 writes address 16383 -> mem_chipselect=0 both cycles; m0_readdata=0 with readdatavalid=1; oob_count=2.
REQ-030 Scenario: freeze high for 3 cycles with m0 reading -> m0_waitrequest=1 and mem_chipselect=0 for 3 cycles; the grant occurs in the first cycle after freeze low.
REQ-031 Scenario: reset_n pulsed low in the cycle after a read grant -> no readdatavalid; outputs at reset values; the next contention is won by m0.
REQ-032 Scenario: 65536 out-of-range accesses -> oob_count holds at 16'hFFFF.
